mario_vram_arb: RTL and testbench
=================================

# mario_vram_arb

Tile VRAM access arbiter. It shares the single-port background VRAM between the main CPU (the decoded VRAM read/write strobes) and the video tile-fetch engine. Video fetches normally win, with a starvation guard so CPU accesses cannot be locked out. The arbiter stretches CPU cycles through WAIT_n until the CPU's access has completed. It sits between the main CPU block's VRAM strobes/data bus and the VRAM instance in the video block.

## Interface
Parameters:
- STARVE_MAX, 4: maximum number of consecutive video grants while a CPU access is pending; legal range 1–7.

Ports:
- I_CLK_48M  in  1  system clock
- I_RESET_n  in  1  asynchronous, active-low reset
- I_CEN_12M  in  1  arbiter tick; all state advances only on clocks where this is high
- I_VBLK_n  in  1  low during vertical blank; CPU gets priority while low
- I_VID_REQ  in  1  video fetch request (level); held until O_VID_ACK
- I_VID_A  in  10  video fetch address
- I_CPU_RD_n  in  1  decoded CPU VRAM read strobe
- I_CPU_WR_n  in  1  decoded CPU VRAM write strobe
- I_CPU_A  in  10  CPU address [9:0]
- I_CPU_D  in  8  CPU write data
- I_RAM_Q  in  8  VRAM read data (synchronous RAM, 1-clock latency)
- O_RAM_A  out  10  VRAM address
- O_RAM_D  out  8  VRAM write data
- O_RAM_WE  out  1  VRAM write enable
- O_VID_Q  out  8  fetched tile byte, valid when O_VID_ACK is high and held until the next video grant
- O_VID_ACK  out  1  one-clock pulse marking fetch completion
- O_CPU_Q  out  8  CPU read data; held until the next CPU grant
- O_WAIT_n  out  1  Z80 WAIT_n

## Operation
- States:
  - IDLE: no access in progress.
  - DATA: access in progress.
- CPU pending: cpu_act = ~I_CPU_RD_n | ~I_CPU_WR_n, and cpu_done = 0.
- cpu_done:
  - Sets when a CPU access completes.
  - Clears on the first tick where cpu_act is 0.
  - Therefore one strobe produces exactly one RAM access.
- Grant decision in IDLE, on a tick:
  - CPU and video both pending: CPU wins if I_VBLK_n = 0 or starve = STARVE_MAX; otherwise video wins.
  - Only one requester pending: that requester wins.
  - Neither pending: stay in IDLE.
- On grant:
  - Register O_RAM_A to the winner's address.
  - CPU write (I_CPU_WR_n = 0): also register O_RAM_D = I_CPU_D and O_RAM_WE = 1.
  - Video grants and CPU reads: O_RAM_WE = 0.
  - Next state is DATA.
  - A write has priority if both strobes are low.
- DATA, on a tick:
  - O_RAM_WE <= 0.
  - Video access: O_VID_Q <= I_RAM_Q and pulse O_VID_ACK.
  - CPU read: O_CPU_Q <= I_RAM_Q.
  - CPU access: set cpu_done.
  - Next state is IDLE.
- starve counter (3 bits):
  - Increments, saturating at STARVE_MAX, on each video grant made while the CPU is pending.
  - Clears on a CPU grant.
  - Clears on any tick where cpu_act = 0.
- O_WAIT_n is combinational: low iff cpu_act = 1 and cpu_done = 0.
- Reset (asynchronous, may occur mid-access):
  - State goes to IDLE; starve = 0; cpu_done = 0.
  - O_RAM_A, O_RAM_D, O_VID_Q, O_CPU_Q = 0.
  - O_RAM_WE = 0 and O_VID_ACK = 0.
  - O_WAIT_n is forced to 1 while I_RESET_n = 0.
  - An in-flight access is abandoned and never acknowledged.

## Timing
- An access occupies 2 ticks (grant tick plus DATA tick), i.e. 8 clocks at a regular 12M enable. The next grant can occur on the tick after DATA.
- O_RAM_WE is high for exactly the clocks between the grant tick and the DATA tick (4 clocks).
- O_VID_ACK is high for exactly one I_CLK_48M cycle, the clock following the DATA tick.
- CPU wait:
  - O_WAIT_n falls in the same clock that a strobe goes active.
  - It rises one clock after the DATA tick of that access.
  - Minimum stretch: the strobe is observed, then 2 ticks.
- Worst-case CPU latency in active display:
  - STARVE_MAX video accesses (2·STARVE_MAX ticks), plus any in-flight access (up to 1 tick).
  - Plus its own access (2 ticks).
- A video request held after ACK is re-granted at the next IDLE tick (back-to-back fetches).
- I_CEN_12M low freezes all state; outputs hold.

## Test plan
- Reset, then idle: all outputs 0 except O_WAIT_n = 1. Assert reset during a DATA-state CPU write: O_RAM_WE = 0 immediately, no ACK, O_WAIT_n = 1.
- CPU write A=0x155, D=0xA5, no video traffic: O_RAM_A = 0x155, O_RAM_WE high for 4 clocks. Read back the same address: O_CPU_Q = 0xA5, O_WAIT_n rises 2 ticks after the strobe.
- Video-only stream, I_VID_REQ held, addresses 0x000..0x00F, RAM preloaded with addr^0x3C: 16 ACK pulses spaced 8 clocks apart, O_VID_Q = addr^0x3C on each.
- Continuous video requests with I_VBLK_n = 1 and a CPU read pending, STARVE_MAX = 4: exactly 4 video grants, then the CPU grant. O_WAIT_n low for 10 ticks, then video resumes.
- I_VBLK_n = 0 with both requests pending on the same tick: CPU granted first; video ACK arrives 2 ticks later.
- CPU strobe held 20 ticks after completion: exactly one RAM access (one WE pulse), O_WAIT_n stays 1. Strobe released then reasserted: a new access occurs.

Source files
------------

// File: rtl/mario_vram_arb.sv
// Tile VRAM arbiter: shares the single-port background VRAM between CPU strobes and the
// video tile fetcher, with a starvation guard and Z80 WAIT_n stretching.
module mario_vram_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic       I_CLK_48M,
    input  logic       I_RESET_n,
    input  logic       I_CEN_12M,
    input  logic       I_VBLK_n,
    input  logic       I_VID_REQ,
    input  logic [9:0] I_VID_A,
    input  logic       I_CPU_RD_n,
    input  logic       I_CPU_WR_n,
    input  logic [9:0] I_CPU_A,
    input  logic [7:0] I_CPU_D,
    input  logic [7:0] I_RAM_Q,
    output logic [9:0] O_RAM_A,
    output logic [7:0] O_RAM_D,
    output logic       O_RAM_WE,
    output logic [7:0] O_VID_Q,
    output logic       O_VID_ACK,
    output logic [7:0] O_CPU_Q,
    output logic       O_WAIT_n
);

    typedef enum logic {IDLE, DATA} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU_RD, OWN_CPU_WR} own_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state, state_nxt;
    own_t       own, own_nxt;
    logic [2:0] starve, starve_nxt;
    logic       cpu_done, cpu_done_nxt;
    logic       cpu_act, cpu_pend;
    logic       grant_cpu, grant_vid, data_tick;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= STARVE_LIM) ? v : v + 3'd1;
    endfunction

    always_comb begin
        cpu_act   = ~I_CPU_RD_n | ~I_CPU_WR_n;
        cpu_pend  = cpu_act & ~cpu_done;
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        data_tick = I_CEN_12M && (state == DATA);
        if (I_CEN_12M && state == IDLE) begin
            // Video normally wins; vblank or a saturated starve count hands the slot to the CPU
            if (cpu_pend && (!I_VID_REQ || !I_VBLK_n || starve == STARVE_LIM))
                grant_cpu = 1'b1;
            else if (I_VID_REQ)
                grant_vid = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        own_nxt      = own;
        starve_nxt   = starve;
        cpu_done_nxt = cpu_done;
        if (I_CEN_12M) begin
            if (grant_cpu) begin
                state_nxt  = DATA;
                own_nxt    = I_CPU_WR_n ? OWN_CPU_RD : OWN_CPU_WR;
                starve_nxt = 3'd0;
            end else if (grant_vid) begin
                state_nxt = DATA;
                own_nxt   = OWN_VID;
                if (cpu_pend)
                    starve_nxt = sat_inc(starve);
            end else if (state == DATA) begin
                state_nxt = IDLE;
                if (own != OWN_VID)
                    cpu_done_nxt = 1'b1;
            end
            // A released strobe re-arms the CPU side so the next strobe gets a fresh access
            if (!cpu_act) begin
                cpu_done_nxt = 1'b0;
                starve_nxt   = 3'd0;
            end
        end
    end

    always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            state    <= IDLE;
            own      <= OWN_VID;
            starve   <= 3'd0;
            cpu_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            own      <= own_nxt;
            starve   <= starve_nxt;
            cpu_done <= cpu_done_nxt;
        end
    end

    always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            O_RAM_A   <= 10'd0;
            O_RAM_D   <= 8'd0;
            O_RAM_WE  <= 1'b0;
            O_VID_Q   <= 8'd0;
            O_VID_ACK <= 1'b0;
            O_CPU_Q   <= 8'd0;
        end else begin
            O_VID_ACK <= 1'b0;
            if (grant_cpu) begin
                O_RAM_A <= I_CPU_A;
                if (!I_CPU_WR_n) begin
                    O_RAM_D  <= I_CPU_D;
                    O_RAM_WE <= 1'b1;
                end else begin
                    O_RAM_WE <= 1'b0;
                end
            end else if (grant_vid) begin
                O_RAM_A  <= I_VID_A;
                O_RAM_WE <= 1'b0;
            end else if (data_tick) begin
                O_RAM_WE <= 1'b0;
                if (own == OWN_VID) begin
                    O_VID_Q   <= I_RAM_Q;
                    O_VID_ACK <= 1'b1;
                end else if (own == OWN_CPU_RD) begin
                    O_CPU_Q <= I_RAM_Q;
                end
            end
        end
    end

    assign O_WAIT_n = ~cpu_pend | ~I_RESET_n;

endmodule

// File: tb/tb_mario_vram_arb.sv
// Bench for mario_vram_arb: directed scenarios plus randomized CPU/video traffic checked
// against a transaction-level model with its own shadow of the VRAM contents.
module tb_mario_vram_arb;

    localparam int STARVE_MAX = 4;

    logic       clk;
    logic       I_RESET_n, I_CEN_12M, I_VBLK_n, I_VID_REQ;
    logic [9:0] I_VID_A, I_CPU_A;
    logic       I_CPU_RD_n, I_CPU_WR_n;
    logic [7:0] I_CPU_D, ram_q;
    logic [9:0] O_RAM_A;
    logic [7:0] O_RAM_D, O_VID_Q, O_CPU_Q;
    logic       O_RAM_WE, O_VID_ACK, O_WAIT_n;

    logic [7:0] mem [1024];
    logic       pre_en;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, cnt_ticks = 0, cnt_wait_ticks = 0, cnt_we = 0, cnt_ack = 0;
    int last_ack = -1, gap_bad = 0;
    bit cen_rand = 0, vid_auto = 0, vid_pattern = 0, rand_mode = 0;
    int cpu_ph = 0, idle_cnt = 0, hold_cnt = 0;

    // reference model state
    logic [7:0] ref_mem [1024];
    bit         m_busy, m_done, m_we, m_ack;
    int         m_owner, m_streak;
    logic [9:0] m_a;
    logic [7:0] m_d, m_vq, m_cq;

    mario_vram_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .I_CLK_48M(clk), .I_RESET_n(I_RESET_n), .I_CEN_12M(I_CEN_12M),
        .I_VBLK_n(I_VBLK_n), .I_VID_REQ(I_VID_REQ), .I_VID_A(I_VID_A),
        .I_CPU_RD_n(I_CPU_RD_n), .I_CPU_WR_n(I_CPU_WR_n), .I_CPU_A(I_CPU_A),
        .I_CPU_D(I_CPU_D), .I_RAM_Q(ram_q), .O_RAM_A(O_RAM_A), .O_RAM_D(O_RAM_D),
        .O_RAM_WE(O_RAM_WE), .O_VID_Q(O_VID_Q), .O_VID_ACK(O_VID_ACK),
        .O_CPU_Q(O_CPU_Q), .O_WAIT_n(O_WAIT_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous single-port VRAM, 1-clock read latency
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (O_RAM_WE) begin
            mem[O_RAM_A] <= O_RAM_D;
        end
        ram_q <= mem[O_RAM_A];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_wait();
        return !I_RESET_n || !((!I_CPU_RD_n || !I_CPU_WR_n) && !m_done);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_we = 0; m_ack = 0;
        m_owner = 0; m_streak = 0;
        m_a = '0; m_d = '0; m_vq = '0; m_cq = '0;
    endtask

    // One arbiter tick of behaviour: a slot is either free (grant) or finishing (data)
    task automatic model_edge();
        bit act, pend;
        if (!I_RESET_n) begin
            model_reset();
            return;
        end
        act   = !I_CPU_RD_n || !I_CPU_WR_n;
        m_ack = 0;
        if (!I_CEN_12M) return;
        pend = act && !m_done;
        if (!m_busy) begin
            if (pend && (!I_VID_REQ || !I_VBLK_n || m_streak == STARVE_MAX)) begin
                m_busy = 1; m_a = I_CPU_A; m_streak = 0;
                if (!I_CPU_WR_n) begin
                    m_owner = 2; m_we = 1; m_d = I_CPU_D; ref_mem[I_CPU_A] = I_CPU_D;
                end else begin
                    m_owner = 1; m_we = 0;
                end
            end else if (I_VID_REQ) begin
                m_busy = 1; m_a = I_VID_A; m_we = 0; m_owner = 0;
                if (pend && m_streak < STARVE_MAX) m_streak++;
            end
        end else begin
            m_busy = 0; m_we = 0;
            if (m_owner == 0) begin
                m_vq = ref_mem[m_a]; m_ack = 1;
            end else begin
                if (m_owner == 1) m_cq = ref_mem[m_a];
                m_done = 1;
            end
        end
        if (!act) begin
            m_done = 0; m_streak = 0;
        end
    endtask

    task automatic compare_all();
        chk("ram_a", 32'(O_RAM_A), 32'(m_a));
        chk("ram_d", 32'(O_RAM_D), 32'(m_d));
        chk("ram_we", 32'(O_RAM_WE), 32'(m_we));
        chk("vid_q", 32'(O_VID_Q), 32'(m_vq));
        chk("vid_ack", 32'(O_VID_ACK), 32'(m_ack));
        chk("cpu_q", 32'(O_CPU_Q), 32'(m_cq));
        chk("wait_n", 32'(O_WAIT_n), 32'(exp_wait()));
    endtask

    task automatic drive_random();
        if (!I_VID_REQ) begin
            if ($urandom_range(0, 3) == 0) begin
                I_VID_REQ = 1'b1; I_VID_A = 10'($urandom);
            end
        end else if (O_VID_ACK) begin
            if ($urandom_range(0, 1) == 1) I_VID_REQ = 1'b0;
            else I_VID_A = 10'($urandom);
        end
        if ($urandom_range(0, 63) == 0) I_VBLK_n = ~I_VBLK_n;
        case (cpu_ph)
            0: if (idle_cnt == 0) begin
                   I_CPU_A = 10'($urandom); I_CPU_D = 8'($urandom);
                   if ($urandom_range(0, 1) == 1) I_CPU_WR_n = 1'b0;
                   else I_CPU_RD_n = 1'b0;
                   cpu_ph = 1;
               end else idle_cnt--;
            1: if (O_WAIT_n) begin
                   hold_cnt = $urandom_range(0, 6); cpu_ph = 2;
               end
            default: if (hold_cnt == 0) begin
                   I_CPU_RD_n = 1'b1; I_CPU_WR_n = 1'b1;
                   idle_cnt = $urandom_range(0, 12); cpu_ph = 0;
               end else hold_cnt--;
        endcase
    endtask

    // One I_CLK_48M cycle: set enable, advance model, clock, compare, then drive
    task automatic step();
        #1;
        chk("wait_comb", 32'(O_WAIT_n), 32'(exp_wait()));
        if (cen_rand) I_CEN_12M = I_CEN_12M ? 1'b0 : 1'($urandom_range(0, 1));
        else I_CEN_12M = (cyc % 4 == 3);
        if (I_CEN_12M) cnt_ticks++;
        if (I_CEN_12M && !O_WAIT_n) cnt_wait_ticks++;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (O_RAM_WE) cnt_we++;
        if (O_VID_ACK) begin
            cnt_ack++;
            if (last_ack >= 0 && cyc - last_ack != 8) gap_bad++;
            last_ack = cyc;
            if (vid_pattern) chk("vid_pattern", 32'(O_VID_Q), 32'(8'(I_VID_A) ^ 8'h3C));
            if (vid_auto) I_VID_A = (I_VID_A + 10'd1) & 10'h00F;
        end
        if (rand_mode) drive_random();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        cnt_ticks = 0; cnt_wait_ticks = 0; cnt_we = 0; cnt_ack = 0;
    endtask

    task automatic run_until_wait(input string tag);
        int n;
        n = 0;
        do begin
            step(); n++;
        end while (!O_WAIT_n && n < 400);
        chk({tag, "_wait_release"}, 32'(O_WAIT_n), 32'd1);
    endtask

    initial begin
        int n;
        I_RESET_n = 1'b0; I_CEN_12M = 1'b0; I_VBLK_n = 1'b1; I_VID_REQ = 1'b0;
        I_VID_A = '0; I_CPU_A = '0; I_CPU_D = '0; I_CPU_RD_n = 1'b1; I_CPU_WR_n = 1'b1;
        pre_en = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
        model_reset();

        // reset and idle
        steps(2);
        pre_en = 1'b0;
        steps(4);
        chk("rst_wait", 32'(O_WAIT_n), 32'd1);
        chk("rst_we", 32'(O_RAM_WE), 32'd0);
        I_RESET_n = 1'b1;
        steps(12);
        chk("idle_ram_a", 32'(O_RAM_A), 32'd0);
        chk("idle_ack", 32'(O_VID_ACK), 32'd0);

        // CPU write then read back
        I_CPU_A = 10'h155; I_CPU_D = 8'hA5; I_CPU_WR_n = 1'b0;
        clr_cnt();
        run_until_wait("wr");
        chk("wr_we_clocks", 32'(cnt_we), 32'd4);
        chk("wr_addr", 32'(O_RAM_A), 32'h155);
        I_CPU_WR_n = 1'b1;
        steps(8);
        I_CPU_RD_n = 1'b0;
        clr_cnt();
        run_until_wait("rd");
        chk("rd_data", 32'(O_CPU_Q), 32'hA5);
        chk("rd_wait_ticks", 32'(cnt_wait_ticks), 32'd2);
        I_CPU_RD_n = 1'b1;
        steps(8);

        // video-only back-to-back stream
        vid_auto = 1; vid_pattern = 1; last_ack = -1; gap_bad = 0;
        I_VID_A = 10'h000; I_VID_REQ = 1'b1;
        clr_cnt();
        n = 0;
        while (cnt_ack < 16 && n < 300) begin
            step(); n++;
        end
        I_VID_REQ = 1'b0; vid_pattern = 0;
        chk("vid_acks", 32'(cnt_ack), 32'd16);
        chk("vid_ack_gap", 32'(gap_bad), 32'd0);
        steps(12);

        // starvation guard in active display
        I_VID_A = 10'h000; I_VID_REQ = 1'b1;
        clr_cnt();
        n = 0;
        do begin step(); n++; end while (!O_VID_ACK && n < 100);
        chk("starve_first_ack", 32'(O_VID_ACK), 32'd1);
        I_CPU_A = 10'h155; I_CPU_RD_n = 1'b0;
        clr_cnt();
        run_until_wait("starve");
        chk("starve_wait_ticks", 32'(cnt_wait_ticks), 32'd10);
        chk("starve_vid_grants", 32'(cnt_ack), 32'd4);
        chk("starve_cpu_q", 32'(O_CPU_Q), 32'hA5);
        I_CPU_RD_n = 1'b1;
        clr_cnt();
        steps(12);
        chk("starve_vid_resume", 32'(cnt_ack), 32'd1);
        I_VID_REQ = 1'b0; vid_auto = 0;
        steps(16);

        // vertical blank: CPU first, video two ticks after it
        I_VBLK_n = 1'b0; I_VID_REQ = 1'b1; I_VID_A = 10'h007;
        I_CPU_A = 10'h155; I_CPU_RD_n = 1'b0;
        clr_cnt();
        n = 0;
        do begin step(); n++; end while (cnt_ticks < 1 && n < 10);
        chk("vblk_first_addr", 32'(O_RAM_A), 32'h155);
        run_until_wait("vblk");
        chk("vblk_wait_ticks", 32'(cnt_wait_ticks), 32'd2);
        I_CPU_RD_n = 1'b1;
        cnt_ticks = 0;
        n = 0;
        do begin step(); n++; end while (!O_VID_ACK && n < 40);
        I_VID_REQ = 1'b0;
        chk("vblk_vid_ticks", 32'(cnt_ticks), 32'd2);
        chk("vblk_vid_q", 32'(O_VID_Q), 32'h3B);
        I_VBLK_n = 1'b1;
        steps(8);

        // held strobe gives a single access; re-strobe gives another
        I_CPU_A = 10'h2AA; I_CPU_D = 8'h5A; I_CPU_WR_n = 1'b0;
        clr_cnt();
        run_until_wait("hold");
        steps(80);
        chk("hold_we_clocks", 32'(cnt_we), 32'd4);
        I_CPU_WR_n = 1'b1;
        steps(8);
        I_CPU_D = 8'h66; I_CPU_WR_n = 1'b0;
        run_until_wait("rewrite");
        chk("rewrite_we_clocks", 32'(cnt_we), 32'd8);
        I_CPU_WR_n = 1'b1;
        steps(8);

        // reset in the middle of a CPU write
        I_CPU_A = 10'h0AB; I_CPU_D = 8'h11; I_CPU_WR_n = 1'b0;
        n = 0;
        do begin step(); n++; end while (!O_RAM_WE && n < 20);
        steps(2);
        chk("midrst_we_before", 32'(O_RAM_WE), 32'd1);
        #2;
        I_RESET_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_we", 32'(O_RAM_WE), 32'd0);
        chk("midrst_ack", 32'(O_VID_ACK), 32'd0);
        chk("midrst_wait", 32'(O_WAIT_n), 32'd1);
        I_CPU_WR_n = 1'b1;
        clr_cnt();
        steps(3);
        I_RESET_n = 1'b1;
        steps(12);
        chk("midrst_no_ack", 32'(cnt_ack), 32'd0);

        // randomized traffic with jittered enable
        cen_rand = 1; rand_mode = 1; cpu_ph = 0; idle_cnt = 3;
        steps(4000);
        rand_mode = 0; cen_rand = 0;
        I_CPU_RD_n = 1'b1; I_CPU_WR_n = 1'b1; I_VID_REQ = 1'b0;
        steps(16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
